// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 64;
    localparam int unsigned INST_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] inst;
        logic                  fault;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory request/response channel between fetch (master) and memory (slave).
interface inst_fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF
);
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [INST_W-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetched entries; clear empties it and overrides push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type         T     = fetch_entry_t,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 push,
    input  T                     push_data,
    input  logic                 pop,
    output T                     head,
    output logic                 valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T               mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop & valid;
    // Gate the head so an empty FIFO presents all-zero outputs.
    assign head   = valid ? mem_q[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem_q[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues PC to memory, buffers {pc, inst, fault} toward decode, handles flush.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_en,
    input  logic              flush,
    inst_fetch_if.master      mem,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    input  logic              inst_ready
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              fault;
    } entry_t;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              outst;
    logic              outst_nxt;
    logic [ADDR_W-1:0] pc_lat;
    logic [CW-1:0]     count;
    logic [CW:0]       used;
    logic              credit;
    logic              aligned;
    logic              req_fire;
    logic              push;
    entry_t            push_entry;
    entry_t            head;

    // Credit uses registered occupancy only; a same-cycle pop does not free a slot.
    assign used     = {1'b0, count} + (CW+1)'(outst);
    assign credit   = used < (CW+1)'(DEPTH);
    assign aligned  = (pc_addr[1:0] == 2'b00);
    assign req_fire = mem.mem_req_valid & mem.mem_req_ready;

    assign mem.mem_req_addr = pc_addr;
    assign pc_en            = (req_fire | flush) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            outst <= 1'b0;
        end else begin
            state <= state_nxt;
            outst <= outst_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            pc_lat <= pc_addr;
    end

    always_comb begin
        state_nxt = state;
        outst_nxt = outst;
        unique case (state)
            IDLE: begin
                if (!flush) begin
                    if (req_fire) begin
                        state_nxt = WAIT;
                        outst_nxt = 1'b1;
                    end else if (push) begin
                        state_nxt = FAULT;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    if (mem.mem_rsp_valid) begin
                        state_nxt = IDLE;
                        outst_nxt = 1'b0;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else if (mem.mem_rsp_valid && !req_fire) begin
                    state_nxt = IDLE;
                    outst_nxt = 1'b0;
                end
            end
            DRAIN: begin
                if (!flush && mem.mem_rsp_valid) begin
                    state_nxt = IDLE;
                    outst_nxt = 1'b0;
                end
            end
            FAULT: begin
                if (flush)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req_valid = 1'b0;
        push              = 1'b0;
        push_entry        = '0;
        if (!reset && !flush) begin
            unique case (state)
                IDLE: begin
                    mem.mem_req_valid = credit & aligned;
                    if (credit && !aligned) begin
                        push             = 1'b1;
                        push_entry.pc    = pc_addr;
                        push_entry.fault = 1'b1;
                    end
                end
                WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        push              = 1'b1;
                        push_entry.pc     = pc_lat;
                        push_entry.inst   = mem.mem_rsp_data;
                        mem.mem_req_valid = credit & aligned;
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (inst_ready),
        .head      (head),
        .valid     (inst_valid),
        .count     (count)
    );

    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;
    assign inst_fault = head.fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a PC model and variable-latency memory model.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic        pc_en;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        inst_ready;

    logic [63:0] target;
    logic [63:0] exp_next;
    logic [63:0] pc_hold;
    logic [63:0] paddr;
    int          lat;
    int          cnt;
    logic        pend;
    int          n_pops;
    int          vectors;
    int          miscompares;

    inst_fetch_if #(.ADDR_W(64), .INST_W(32)) mif ();

    inst_fetch #(
        .ADDR_W (64),
        .INST_W (32),
        .DEPTH  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc),
        .pc_en      (pc_en),
        .flush      (flush),
        .mem        (mif),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .inst_fault (inst_fault),
        .inst_ready (inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: scoreboard pops, advance PC on pc_en, run the memory model.
    task automatic tick();
        logic        hs;
        logic        pe;
        logic        fl;
        logic [63:0] ha;
        hs = mif.mem_req_valid & mif.mem_req_ready;
        ha = mif.mem_req_addr;
        pe = pc_en;
        fl = flush;
        if (inst_valid && inst_ready && !flush && !reset) begin
            chk("pop_pc", inst_pc, exp_next);
            chk("pop_data", {32'h0, inst_data}, {32'h0, 16'hC0DE, exp_next[15:0]});
            exp_next = exp_next + 64'd4;
            n_pops++;
        end
        @(posedge clk);
        #1;
        if (pe) pc = fl ? target : pc + 64'd4;
        mif.mem_rsp_valid = 1'b0;
        mif.mem_rsp_data  = '0;
        if (hs) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = ha;
        end
        if (pend) begin
            if (cnt <= 1) begin
                mif.mem_rsp_valid = 1'b1;
                mif.mem_rsp_data  = {16'hC0DE, paddr[15:0]};
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end
        #1;
    endtask

    task automatic run_pops(input int n);
        int goal;
        goal = n_pops + n;
        for (int i = 0; i < 40 && n_pops < goal; i++) tick();
        chk("pop_budget", 64'(n_pops >= goal), 64'd1);
    endtask

    // Hold memory off until the unit sits in IDLE with an empty FIFO and a pending request.
    task automatic quiesce();
        logic ok;
        ok = 1'b0;
        mif.mem_req_ready = 1'b0;
        #1;
        for (int i = 0; i < 30; i++) begin
            if (!inst_valid && mif.mem_req_valid && !mif.mem_rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("quiesce", ok, 1);
    endtask

    initial begin
        vectors = 0; miscompares = 0; n_pops = 0;
        reset = 1'b1; flush = 1'b0; inst_ready = 1'b1;
        pc = '0; target = '0; exp_next = '0; pc_hold = '0;
        lat = 1; cnt = 0; pend = 1'b0; paddr = '0;
        mif.mem_req_ready = 1'b1;
        mif.mem_rsp_valid = 1'b0;
        mif.mem_rsp_data  = '0;

        // reset state
        tick(); tick();
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_fault", inst_fault, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_req_valid", mif.mem_req_valid, 0);

        // first fetch, 1-cycle memory
        reset = 1'b0; #1;
        chk("c0_req_valid", mif.mem_req_valid, 1);
        chk("c0_req_addr", mif.mem_req_addr, 64'h0);
        chk("c0_pc_en", pc_en, 1);
        tick();
        chk("c1_inst_valid", inst_valid, 0);
        chk("c1_req_addr", mif.mem_req_addr, 64'h4);
        tick();
        chk("c2_inst_valid", inst_valid, 1);
        chk("c2_inst_pc", inst_pc, 64'h0);
        chk("c2_inst_data", inst_data, 32'hC0DE0000);
        tick();
        chk("c3_inst_valid", inst_valid, 1);
        chk("c3_inst_pc", inst_pc, 64'h4);
        run_pops(2);

        // decode stall: FIFO fills to two entries and requests stop
        inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("hold_valid", inst_valid, 1);
        chk("hold_pc", inst_pc, exp_next);
        chk("hold_req_valid", mif.mem_req_valid, 0);
        chk("hold_pc_en", pc_en, 0);
        inst_ready = 1'b1; #1;
        chk("rel0_valid", inst_valid, 1);
        tick();
        chk("rel1_valid", inst_valid, 1);
        tick();
        chk("rel2_valid", inst_valid, 0);

        // memory not ready: PC must hold
        mif.mem_req_ready = 1'b0;
        pc_hold = pc;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("nrdy_pc_en", pc_en, 0);
            chk("nrdy_addr", mif.mem_req_addr, pc_hold);
            tick();
        end
        chk("nrdy_req_valid", mif.mem_req_valid, 1);
        chk("nrdy_pc_en_end", pc_en, 0);

        // flush one cycle after handshake, response lands in DRAIN
        quiesce();
        lat = 3;
        mif.mem_req_ready = 1'b1; #1;
        chk("fw_hs_pc_en", pc_en, 1);
        tick();
        flush = 1'b1; target = 64'h40; #1;
        chk("fw_flush_pc_en", pc_en, 1);
        chk("fw_flush_req", mif.mem_req_valid, 0);
        tick();
        flush = 1'b0; exp_next = 64'h40; #1;
        chk("fw_drain_req", mif.mem_req_valid, 0);
        chk("fw_drain_valid", inst_valid, 0);
        tick();
        chk("fw_stale_req", mif.mem_req_valid, 0);
        tick();
        chk("fw_idle_req", mif.mem_req_valid, 1);
        chk("fw_idle_addr", mif.mem_req_addr, 64'h40);
        lat = 1;
        tick(); tick();
        chk("fw_new_valid", inst_valid, 1);
        chk("fw_new_pc", inst_pc, 64'h40);

        // flush coincident with a response while one entry is buffered
        quiesce();
        inst_ready = 1'b0; lat = 1;
        mif.mem_req_ready = 1'b1; #1;
        tick(); tick();
        chk("fr_one_entry", inst_valid, 1);
        flush = 1'b1; target = 64'h80; #1;
        chk("fr_pc_en", pc_en, 1);
        chk("fr_req", mif.mem_req_valid, 0);
        tick();
        flush = 1'b0; exp_next = 64'h80; inst_ready = 1'b1; #1;
        chk("fr_cleared", inst_valid, 0);
        chk("fr_req_tgt", mif.mem_req_valid, 1);
        chk("fr_addr_tgt", mif.mem_req_addr, 64'h80);
        tick(); tick();
        chk("fr_new_valid", inst_valid, 1);
        chk("fr_new_pc", inst_pc, 64'h80);

        // misaligned target: fault entry, PC frozen until flush
        quiesce();
        inst_ready = 1'b0;
        flush = 1'b1; target = 64'h42;
        mif.mem_req_ready = 1'b1; #1;
        chk("mf_flush_pc_en", pc_en, 1);
        chk("mf_flush_req", mif.mem_req_valid, 0);
        tick();
        flush = 1'b0; #1;
        chk("mf_req", mif.mem_req_valid, 0);
        chk("mf_pc_en", pc_en, 0);
        tick();
        chk("mf_valid", inst_valid, 1);
        chk("mf_fault", inst_fault, 1);
        chk("mf_pc", inst_pc, 64'h42);
        chk("mf_data", inst_data, 0);
        tick(); tick();
        chk("mf_hold_pc_en", pc_en, 0);
        chk("mf_hold_req", mif.mem_req_valid, 0);
        chk("mf_hold_valid", inst_valid, 1);
        flush = 1'b1; target = 64'h100; #1;
        chk("mf_exit_pc_en", pc_en, 1);
        tick();
        flush = 1'b0; exp_next = 64'h100; inst_ready = 1'b1; lat = 3; #1;
        chk("mf_exit_valid", inst_valid, 0);
        chk("mf_exit_req", mif.mem_req_valid, 1);
        chk("mf_exit_addr", mif.mem_req_addr, 64'h100);

        // reset while waiting; the late response must be ignored
        tick();
        reset = 1'b1; #1;
        chk("mr_pc_en", pc_en, 0);
        chk("mr_req", mif.mem_req_valid, 0);
        tick();
        chk("mr_inst_valid", inst_valid, 0);
        chk("mr_inst_fault", inst_fault, 0);
        chk("mr_inst_data", inst_data, 0);
        chk("mr_inst_pc", inst_pc, 0);
        chk("mr_pc_en2", pc_en, 0);
        chk("mr_req2", mif.mem_req_valid, 0);
        reset = 1'b0; mif.mem_req_ready = 1'b0; #1;
        tick();
        chk("mr_late_req", mif.mem_req_valid, 1);
        chk("mr_late_pc_en", pc_en, 0);
        tick();
        chk("mr_late_ignored", inst_valid, 0);
        exp_next = pc; lat = 1;
        mif.mem_req_ready = 1'b1; #1;
        chk("mr_resume_addr", mif.mem_req_addr, 64'h104);
        run_pops(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
